p_mul_iter: RTL and testbench

- Iterative, parametrised packed multiplier for the crypto ISE datapath.
- Computes lane-wise integer or carry-less products of two XLEN-bit registers.
- Lane width is selected at run time by a one-hot pack width.
- Processes BPC multiplier bits per cycle, and returns the low or high half of every lane product under a valid/ready handshake.

---
 rtl/p_mul_iter.sv | 188 ++++++++++++++++++
 tb/tb_p_mul_iter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/p_mul_iter.sv
// Iterative packed multiplier: lane-wise integer or carry-less products, BPC multiplier bits per cycle.
// Optional signed operands enabled by defining P_MUL_SIGNED_EN (adds sign_a/sign_b ports).
//
// state | meaning
// IDLE  | waiting for valid; clears accumulator and counter on acceptance
// BUSY  | accumulating BPC partial products per lane per cycle
// DONE  | result presented, ready pulses for one cycle
module p_mul_iter #(
  parameter  int XLEN = 32,
  parameter  int BPC  = 4,
  localparam int PW_W = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid,
  output logic            ready,
  input  logic            mul_l,
  input  logic            mul_h,
  input  logic            clmul,
`ifdef P_MUL_SIGNED_EN
  input  logic            sign_a,
  input  logic            sign_b,
`endif
  input  logic [PW_W-1:0] pw,
  input  logic [XLEN-1:0] crs1,
  input  logic [XLEN-1:0] crs2,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [CNT_W-1:0]             cnt;
  logic [2*XLEN-1:0]            acc;
  logic [2*XLEN-1:0]            acc_nxt;
  logic [XLEN-1:0]              res_sel;
  logic [CNT_W-1:0]             cnt_last;
  logic [PW_W-1:0]              w_sel;
  logic [PW_W-1:0][2*XLEN-1:0]  acc_nxt_w;
  logic [PW_W-1:0][XLEN-1:0]    res_w;
  logic [PW_W-1:0][CNT_W-1:0]   last_w;
  logic                         sa;
  logic                         sb;

`ifdef P_MUL_SIGNED_EN
  assign sa = sign_a & ~clmul;
  assign sb = sign_b & ~clmul;
`else
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif

  // Lowest set bit of pw picks the lane width; pw==0 falls back to one full-width lane.
  assign w_sel = (pw == '0) ? PW_W'(1) : (pw & (~pw + PW_W'(1)));

  for (genvar w = 0; w < PW_W; w++) begin : g_w
    localparam int L  = XLEN >> w;
    localparam int NL = XLEN / L;
    localparam int N  = ((L / BPC) > 1) ? (L / BPC) : 1;

    logic [2*XLEN-1:0] nxt;
    logic [XLEN-1:0]   res;
    logic [L-1:0]      a_l;
    logic [L-1:0]      b_l;
    logic [L-1:0]      b_sh;
    logic [2*L-1:0]    a_ext;
    logic [2*L-1:0]    pp;
    logic [2*L-1:0]    sl;
    int                idx;

    always_comb begin
      nxt   = acc;
      res   = '0;
      a_l   = '0;
      b_l   = '0;
      b_sh  = '0;
      a_ext = '0;
      pp    = '0;
      sl    = '0;
      idx   = 0;
      for (int k = 0; k < NL; k++) begin
        a_l   = crs1[k*L +: L];
        b_l   = crs2[k*L +: L];
        a_ext = {{L{sa & a_l[L-1]}}, a_l};
        sl    = acc[k*2*L +: 2*L];
        for (int j = 0; j < BPC; j++) begin
          idx = int'(cnt) * BPC + j;
          if (idx < L) begin
            b_sh = b_l >> idx;
            pp   = a_ext << idx;
            if (b_sh[0]) begin
              if (clmul)
                sl = sl ^ pp;
              else if (sb && (idx == L - 1))
                sl = sl - pp;  // signed multiplier: MSB weight is negative
              else
                sl = sl + pp;
            end
          end
        end
        nxt[k*2*L +: 2*L] = sl;
        if (mul_l)
          res[k*L +: L] = acc[k*2*L +: L];
        else if (mul_h)
          res[k*L +: L] = acc[k*2*L+L +: L];
      end
    end

    assign acc_nxt_w[w] = nxt;
    assign res_w[w]     = res;
    assign last_w[w]    = CNT_W'(N - 1);
  end

  always_comb begin
    acc_nxt  = '0;
    res_sel  = '0;
    cnt_last = '0;
    for (int w = 0; w < PW_W; w++) begin
      if (w_sel[w]) begin
        acc_nxt  = acc_nxt_w[w];
        res_sel  = res_w[w];
        cnt_last = last_w[w];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (valid)
          state_nxt = BUSY;
      end
      BUSY: begin
        if (!valid)
          state_nxt = IDLE;
        else if (cnt == cnt_last)
          state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        BUSY: begin
          if (valid) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result = ready ? res_sel : '0;

endmodule

// File: tb/tb_p_mul_iter.sv
// Directed self-checking bench for p_mul_iter (XLEN=32, BPC=4).
// Signed vectors are exercised only when P_MUL_SIGNED_EN is defined.
module tb_p_mul_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic        mul_l;
  logic        mul_h;
  logic        clmul;
  logic        sign_a;
  logic        sign_b;
  logic [4:0]  pw;
  logic [31:0] crs1;
  logic [31:0] crs2;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  p_mul_iter #(.XLEN(32), .BPC(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .valid  (valid),
    .ready  (ready),
    .mul_l  (mul_l),
    .mul_h  (mul_h),
    .clmul  (clmul),
`ifdef P_MUL_SIGNED_EN
    .sign_a (sign_a),
    .sign_b (sign_b),
`endif
    .pw     (pw),
    .crs1   (crs1),
    .crs2   (crs2),
    .result (result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] p, input logic ml, input logic mh,
                        input logic cl, input logic sa, input logic sb,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    logic [31:0] res;
    pw = p; mul_l = ml; mul_h = mh; clmul = cl; sign_a = sa; sign_b = sb;
    crs1 = a; crs2 = b;
    valid = 1'b1;
    lat = 0;
    res = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (c == 1) chk({tag, "_busy_res"}, result, 32'h0);
      if (ready) begin
        lat = c;
        res = result;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, res, exp);
    valid = 1'b0;
    @(posedge clock); #1;
    chk({tag, "_rdy_drop"}, {31'b0, ready}, 32'h0);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clock); #1;
      if (ready) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int lat1;
    int lat2;
    logic [31:0] r1;
    logic [31:0] r2;

    reset = 1'b1; valid = 1'b0; mul_l = 1'b0; mul_h = 1'b0; clmul = 1'b0;
    sign_a = 1'b0; sign_b = 1'b0; pw = '0; crs1 = '0; crs2 = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_result", result, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("s1_l32",  5'b00001, 1, 0, 0, 0, 0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 9);
    run_op("s1_h32",  5'b00001, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 9);
    run_op("s1_none", 5'b00001, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 9);
    run_op("s2_l16",  5'b00010, 1, 0, 0, 0, 0, 32'hFFFF0003, 32'h00020005, 32'hFFFE000F, 5);
    run_op("s2_h16",  5'b00010, 0, 1, 0, 0, 0, 32'hFFFF0003, 32'h00020005, 32'h00010000, 5);
    run_op("s2_lpri", 5'b00010, 1, 1, 0, 0, 0, 32'hFFFF0003, 32'h00020005, 32'hFFFE000F, 5);
    run_op("s3_cl_l", 5'b00100, 1, 0, 1, 0, 0, 32'h03030303, 32'h03030303, 32'h05050505, 3);
    run_op("s3_cl_h", 5'b00100, 0, 1, 1, 0, 0, 32'h03030303, 32'h03030303, 32'h00000000, 3);
    run_op("s4_l2",   5'b10000, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 2);
    run_op("s4_h2",   5'b10000, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 2);
    run_op("s4_pw0",  5'b00000, 1, 0, 0, 0, 0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 9);
    run_op("s4_pwlo", 5'b10010, 1, 0, 0, 0, 0, 32'hFFFF0003, 32'h00020005, 32'hFFFE000F, 5);

    // Back-to-back with valid held: one result every N+2 cycles.
    pw = 5'b10000; mul_l = 1'b1; mul_h = 1'b0; clmul = 1'b0;
    crs1 = 32'hFFFFFFFF; crs2 = 32'hFFFFFFFF; valid = 1'b1;
    lat1 = 0; lat2 = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (ready) begin lat1 = c; r1 = result; break; end
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (ready) begin lat2 = c; r2 = result; break; end
    end
    valid = 1'b0;
    chk("b2b_lat1", lat1, 2);
    chk("b2b_res1", r1, 32'h55555555);
    chk("b2b_lat2", lat2, 3);
    chk("b2b_res2", r2, 32'h55555555);
    @(posedge clock); #1;

    // Abort: valid dropped in the third BUSY cycle.
    pw = 5'b00001; mul_l = 1'b1; crs1 = 32'h0000FFFF; crs2 = 32'h0000FFFF; valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    valid = 1'b0;
    count_pulses(14, pulses);
    chk("abort_no_ready", pulses, 0);
    run_op("abort_next", 5'b00001, 1, 0, 0, 0, 0, 32'h00001234, 32'h00000010, 32'h00012340, 9);

    // Synchronous reset while BUSY.
    pw = 5'b00001; mul_l = 1'b1; crs1 = 32'h0000FFFF; crs2 = 32'h0000FFFF; valid = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    valid = 1'b0;
    @(posedge clock); #1;
    chk("rst_mid_ready", {31'b0, ready}, 32'h0);
    chk("rst_mid_result", result, 32'h0);
    reset = 1'b0;
    count_pulses(14, pulses);
    chk("rst_mid_idle", pulses, 0);
    run_op("rst_next", 5'b00010, 0, 1, 0, 0, 0, 32'hFFFF0003, 32'h00020005, 32'h00010000, 5);

`ifdef P_MUL_SIGNED_EN
    run_op("s6_h_ss", 5'b00010, 0, 1, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5);
    run_op("s6_h_uu", 5'b00010, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFEFFFE, 5);
    run_op("s6_l_ss", 5'b00010, 1, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010001, 5);
    run_op("s6_l_uu", 5'b00010, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010001, 5);
    run_op("s6_cl_ss", 5'b00100, 1, 0, 1, 1, 1, 32'h03030303, 32'h03030303, 32'h05050505, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
